// File: rtl/uart_frame_tx.sv
// UART transmitter fed by a small FIFO: frames each queued word as
// start + LSB-first data + optional parity + stop bit(s).
module uart_frame_tx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          tx,
  output logic                          busy,
  output logic                          done
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] RELOAD    = CW'(DIV - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    parity_of = (^d) ^ (PARITY == 1);
  endfunction

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q, count_d;
  logic                 overflow_q;
  logic                 full_w, push, pop;
  logic [DATA_BITS-1:0] head;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tick, launch;

  // Fullness is judged on the registered count, so a pop on the same
  // edge never rescues a write that arrives while full.
  assign full_w = (count_q == DEPTH);
  assign push   = wr_en && !full_w;
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + (AW + 1)'(1);
    else if (!push && pop)
      count_d = count_q - (AW + 1)'(1);
  end

  always_ff @(posedge sysclk) begin
    if (push)
      mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      overflow_q <= wr_en && full_w;
    end
  end

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    launch  = 1'b0;

    if (state_q != IDLE && !tick)
      cnt_d = cnt_q - CW'(1);

    case (state_q)
      IDLE: begin
        if (count_q != '0)
          launch = 1'b1;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          cnt_d   = RELOAD;
          bit_d   = '0;
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d = RELOAD;
          if (bit_q == LAST_DATA) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = PAR;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end
      end
      PAR: begin
        if (tick) begin
          state_d = STOP;
          cnt_d   = RELOAD;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_q == LAST_STOP) begin
            done_d = 1'b1;
            bit_d  = '0;
            if (count_q != '0) begin
              launch = 1'b1;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            cnt_d = RELOAD;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Launching from STOP reuses the same edge, so back-to-back frames
    // have no idle gap between stop and start.
    if (launch) begin
      pop     = 1'b1;
      state_d = START;
      cnt_d   = RELOAD;
      bit_d   = '0;
      sh_d    = head;
      par_d   = parity_of(head);
      tx_d    = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    sh_q  <= sh_d;
    par_q <= par_d;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign full     = full_w;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: three small-divider instances
// (8N1 with rounded divider, 7E2, 7O2) driven from one linear sequence.
module tb_uart_frame_tx;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  int         sel;

  int nvec = 0;
  int nerr = 0;

  logic       wr_en_a, wr_en_b, wr_en_c;
  logic       full_a, ovf_a, tx_a, busy_a, done_a;
  logic [4:0] count_a;
  logic       full_b, ovf_b, tx_b, busy_b, done_b;
  logic [2:0] count_b;
  logic       full_c, ovf_c, tx_c, busy_c, done_c;
  logic [2:0] count_c;
  logic       tx_s, busy_s, done_s;

  always #5 sysclk = ~sysclk;

  assign wr_en_a = wr_en && (sel == 0);
  assign wr_en_b = wr_en && (sel == 1);
  assign wr_en_c = wr_en && (sel == 2);

  always_comb begin
    tx_s   = tx_a;
    busy_s = busy_a;
    done_s = done_a;
    if (sel == 1) begin
      tx_s   = tx_b;
      busy_s = busy_b;
      done_s = done_b;
    end else if (sel == 2) begin
      tx_s   = tx_c;
      busy_s = busy_c;
      done_s = done_c;
    end
  end

  // 86/10 = 8.6 rounds to a 9-cycle bit period
  uart_frame_tx #(.CLK_HZ(86), .BAUD(10)) dut_a (
    .sysclk(sysclk), .reset(reset), .wr_en(wr_en_a), .wr_data(wr_data),
    .full(full_a), .count(count_a), .overflow(ovf_a),
    .tx(tx_a), .busy(busy_a), .done(done_a));

  uart_frame_tx #(.CLK_HZ(40), .BAUD(10), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .sysclk(sysclk), .reset(reset), .wr_en(wr_en_b), .wr_data(wr_data[6:0]),
    .full(full_b), .count(count_b), .overflow(ovf_b),
    .tx(tx_b), .busy(busy_b), .done(done_b));

  uart_frame_tx #(.CLK_HZ(40), .BAUD(10), .DATA_BITS(7), .PARITY(1),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
    .sysclk(sysclk), .reset(reset), .wr_en(wr_en_c), .wr_data(wr_data[6:0]),
    .full(full_c), .count(count_c), .overflow(ovf_c),
    .tx(tx_c), .busy(busy_c), .done(done_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered on the first negedge of a start bit; returns on the negedge
  // just after the final stop-bit edge.
  task automatic run_frame(input string tag, input logic [15:0] bits,
                           input int nb, input int div, input logic nxt);
    for (int i = 0; i < nb; i++) begin
      int bad;
      bad = 0;
      for (int c = 0; c < div; c++) begin
        if (tx_s !== bits[i] || busy_s !== 1'b1) bad++;
        if (done_s !== 1'b0 && !(i == 0 && c == 0)) bad++;
        @(negedge sysclk);
      end
      chk($sformatf("%s bit%0d", tag, i), bad, 0);
    end
    chk($sformatf("%s done", tag), done_s, 1);
    chk($sformatf("%s busy_after", tag), busy_s, nxt);
    chk($sformatf("%s tx_after", tag), tx_s, !nxt);
  endtask

  initial begin
    logic [7:0] b;
    int n;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    sel     = 0;
    repeat (2) @(negedge sysclk);
    chk("rst tx", tx_a, 1);
    chk("rst busy", busy_a, 0);
    chk("rst done", done_a, 0);
    chk("rst ovf", ovf_a, 0);
    chk("rst full", full_a, 0);
    chk("rst count", count_a, 0);
    chk("rst b", {full_b, ovf_b, count_b, tx_b}, 32'h1);
    chk("rst c", {full_c, ovf_c, count_c, tx_c}, 32'h1);
    reset = 1'b0;
    @(negedge sysclk);

    // single 0x1B frame
    wr_data = 8'h1B; wr_en = 1'b1;
    @(negedge sysclk);
    wr_en = 1'b0;
    chk("nofall count", count_a, 1);
    chk("nofall tx", tx_a, 1);
    @(negedge sysclk);
    chk("pop tx", tx_a, 0);
    chk("pop busy", busy_a, 1);
    chk("pop count", count_a, 0);
    run_frame("f1B", {6'b0, 1'b1, 8'h1B, 1'b0}, 10, 9, 1'b0);
    @(negedge sysclk);
    chk("f1B done_pulse", done_a, 0);
    chk("f1B idle tx", tx_a, 1);

    // 0x1B then 0x78 back to back
    wr_data = 8'h1B; wr_en = 1'b1;
    @(negedge sysclk);
    wr_data = 8'h78;
    @(negedge sysclk);
    wr_en = 1'b0;
    chk("b2b start", tx_a, 0);
    chk("b2b count", count_a, 1);
    run_frame("b2b_1B", {6'b0, 1'b1, 8'h1B, 1'b0}, 10, 9, 1'b1);
    run_frame("b2b_78", {6'b0, 1'b1, 8'h78, 1'b0}, 10, 9, 1'b0);
    @(negedge sysclk);
    chk("b2b done_pulse", done_a, 0);

    // 7E2: 0x55 has four ones, even parity bit 0
    sel = 1;
    wr_data = 8'h55; wr_en = 1'b1;
    @(negedge sysclk);
    wr_en = 1'b0;
    @(negedge sysclk);
    chk("7E2 start", tx_s, 0);
    run_frame("7E2", {5'b0, 2'b11, 1'b0, 7'h55, 1'b0}, 11, 4, 1'b0);
    chk("7E2 count", count_b, 0);
    @(negedge sysclk);

    // 7O2: odd parity bit 1
    sel = 2;
    wr_data = 8'h55; wr_en = 1'b1;
    @(negedge sysclk);
    wr_en = 1'b0;
    @(negedge sysclk);
    chk("7O2 start", tx_s, 0);
    run_frame("7O2", {5'b0, 2'b11, 1'b1, 7'h55, 1'b0}, 11, 4, 1'b0);
    chk("7O2 count", count_c, 0);
    @(negedge sysclk);

    // 18 consecutive writes into the 16-deep FIFO
    sel = 0;
    for (int i = 0; i < 18; i++) begin
      wr_data = 8'(8'h20 + i);
      wr_en   = 1'b1;
      @(negedge sysclk);
      if (i == 0) chk("fill count0", count_a, 1);
      if (i == 1) chk("fill count1", count_a, 1);
      if (i == 1) chk("fill tx1", tx_a, 0);
      if (i == 16) chk("fill full17", {full_a, ovf_a, count_a}, {25'b0, 1'b1, 1'b0, 5'd16});
      if (i == 17) chk("fill drop18", {full_a, ovf_a, count_a}, {25'b0, 1'b1, 1'b1, 5'd16});
    end
    wr_en = 1'b0;
    @(negedge sysclk);
    chk("ovf pulse end", ovf_a, 0);
    n = 0;
    while (done_a !== 1'b1 && n < 200) begin
      @(negedge sysclk);
      n++;
    end
    chk("fill first done", done_a, 1);
    chk("fill count15", count_a, 15);
    chk("fill next start", tx_a, 0);
    for (int j = 1; j <= 16; j++) begin
      b = 8'(8'h20 + j);
      run_frame($sformatf("fifo%0d", j), {6'b0, 1'b1, b, 1'b0}, 10, 9, j < 16);
    end
    @(negedge sysclk);
    chk("fifo empty", count_a, 0);
    chk("fifo done_pulse", done_a, 0);

    // reset during data bit 3 of 0x13 (that bit is 0), with 0xA5 queued
    wr_data = 8'h13; wr_en = 1'b1;
    @(negedge sysclk);
    wr_data = 8'hA5;
    @(negedge sysclk);
    wr_en = 1'b0;
    repeat (40) @(negedge sysclk);
    chk("mid bit3", tx_a, 0);
    chk("mid count", count_a, 1);
    #2 reset = 1'b1;
    #1;
    chk("async tx", tx_a, 1);
    chk("async count", count_a, 0);
    chk("async busy", busy_a, 0);
    @(negedge sysclk);
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge sysclk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) n++;
    end
    chk("post reset quiet", n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: sysclk frequency in Hz.
REQ-002 Parameter BAUD, default 9600: line bit rate; bit period DIV = round(CLK_HZ/BAUD) cycles (default 5208).
REQ-003 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..8.
REQ-004 Parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 16: entries in the transmit FIFO; power of two, at least 2; other values unsupported.
REQ-007 sysclk  input  1  single clock; all state changes on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 wr_en  input  1  write strobe; pushes wr_data when full=0.
REQ-010 wr_data  input  DATA_BITS  byte to transmit, LSB sent first.
REQ-011 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-012 count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 overflow  output  1  one-cycle pulse when a write is dropped.
REQ-014 tx  output  1  serial line, registered, idle high.
REQ-015 busy  output  1  high while a frame is on the line.
REQ-016 done  output  1  one-cycle pulse in the cycle after a frame's last stop bit ends.

Function
REQ-017 FIFO write: on an edge with wr_en=1 and full=0, wr_data is stored at the tail and count increments.
REQ-018 Fullness is evaluated before a same-edge pop; a write while full is dropped even if a pop occurs on that edge, count is unchanged, and overflow pulses.
REQ-019 No fall-through: a byte written at edge k is poppable no earlier than edge k+1.
REQ-020 A simultaneous push and pop leaves count unchanged; read and write pointers wrap modulo FIFO_DEPTH.
REQ-021 FSM states: IDLE, START, DATA, PAR, STOP.
REQ-022 IDLE with count>0: next edge pops the head into a shift register, enters START, and drives tx=0, busy=1.
REQ-023 Every bit, including start, each data bit, parity and each stop bit, holds tx for exactly DIV cycles, timed by a down-counter reloaded at each bit boundary.
REQ-024 DATA: DATA_BITS bits sent LSB first; then PAR if PARITY!=0, else STOP.
REQ-025 PAR: tx = XOR of the data bits for even parity, or its inverse for odd parity.
REQ-026 STOP: tx=1 for STOP_BITS*DIV cycles.
REQ-027 End of STOP with count>0: the next start bit begins on the immediately following edge, with no idle gap; busy stays 1 and done pulses.
REQ-028 End of STOP with count=0: return to IDLE with tx=1, busy=0, and done pulsing.
REQ-029 Frame length is (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*DIV cycles exactly, with no cumulative drift across frames.
REQ-030 wr_en during a frame never disturbs the frame in flight.

Reset
REQ-031 reset=1 immediately, without waiting for a clock edge, forces tx=1, busy=0, done=0, overflow=0, full=0, count=0, state IDLE, pointers 0, and bit counter 0.
REQ-032 Reset mid-frame aborts the frame and discards all FIFO contents; no frame is emitted after release until a new write.
REQ-033 First pop is possible on the first edge after reset deasserts, given a prior write.

Verification
REQ-034 Defaults, single write 0x1B -> tx low for 5208 cycles, then 1,1,0,1,1,0,0,0 at 5208 cycles each, then high for 5208 cycles; done pulses once, 52080 cycles after the start edge.
REQ-035 Defaults, writes 0x1B then 0x78 on consecutive edges -> 0x78's start bit follows the 0x1B stop bit with zero gap; busy is high for 104160 contiguous cycles; done pulses twice.
REQ-036 DATA_BITS=7, PARITY=2, STOP_BITS=2, write 0x55 -> data 1,0,1,0,1,0,1, parity 0, two stop bits; same with PARITY=1 -> parity 1.
REQ-037 Defaults, 18 writes on consecutive edges from idle -> first byte popped at once; full=1 with count=16 after the 17th write; the 18th write is dropped with an overflow pulse; the 16 remaining bytes emerge in order.
REQ-038 Reset asserted during data bit 3 -> tx=1 and count=0 without a clock edge; after release tx stays high indefinitely with no writes.
